tinyalu_responder: RTL and testbench

//  Synthesizable responder end of the TinyALU start/done operation protocol; the bus-functional initiator drives it.
//  - Accepts A/B/op on a start request and computes add/and/xor/mul.
//  - Returns a 16-bit result with a one-cycle done pulse.
//  - Drop-in DUT for tinyalu_pkg testbenches; opcodes follow operation_t.

---
 rtl/tinyalu_responder.sv | 68 ++++++
 tb/tb_tinyalu_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tinyalu_responder.sv
// tinyalu_responder: TinyALU start/done responder computing add/and/xor/mul on latched operands.
module tinyalu_responder #(
  parameter int DATA_W      = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [2:0]          op,
  input  logic                start,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                busy
);
  localparam int RW = 2 * DATA_W;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010,
                         OP_XOR = 3'b011, OP_MUL = 3'b100, OP_RST = 3'b111;
  typedef enum logic [1:0] {IDLE, SINGLE, MUL, WAIT_LOW} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic [RW-1:0] f;
  logic is_single, accept, fin;
  // Illegal opcodes 101/110 take the single-cycle path and yield zero.
  assign is_single = !(op inside {OP_NOP, OP_MUL, OP_RST});
  assign accept = state == IDLE && start;
  assign fin = state == SINGLE || (state == MUL && cnt == 4'd0);
  assign busy = state == SINGLE || state == MUL;
  always_comb begin
    f = op_q == OP_ADD ? RW'(a_q) + RW'(b_q) :
        op_q == OP_AND ? RW'(a_q & b_q) :
        op_q == OP_XOR ? RW'(a_q ^ b_q) :
        op_q == OP_MUL ? RW'(a_q) * RW'(b_q) : '0;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = is_single ? SINGLE : op == OP_MUL ? MUL : IDLE;
    else if (fin) state_n = WAIT_LOW;
    else if (state == WAIT_LOW && !start) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_NOP;
      cnt    <= '0;
    end else begin
      done <= fin;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
        cnt  <= 4'(MUL_LATENCY - 1);
        if (op == OP_RST) result <= '0;
      end
      if (state == MUL && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (fin) result <= f;
    end
  end
endmodule

// File: tb/tb_tinyalu_responder.sv
// tb_tinyalu_responder: directed checks of the TinyALU responder (MUL_LATENCY 3 and 1).
module tb_tinyalu_responder;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] op = '0;
  logic done, busy, done1, busy1;
  logic [15:0] result, result1;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  tinyalu_responder #(.DATA_W(8), .MUL_LATENCY(3)) u_dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .done(done), .result(result), .busy(busy));
  tinyalu_responder #(.DATA_W(8), .MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .done(done1), .result(result1), .busy(busy1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; A = a; B = b; start = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result !== 16'h0000) begin fails++; $display("FAIL reset_result: got %h expected 0000", result); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int n = 0;
    go(3'b001, 8'hFF, 8'hFF);
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL add_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL add_done: got %b expected 1", done); end
    checks++; if (result !== 16'h01FE) begin fails++; $display("FAIL add_result: got %h expected 01fe", result); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL add_busy_after: got %b expected 0", busy); end
    for (int i = 0; i < 5; i++) begin tick(); n += int'(done); end
    checks++; if (n != 0) begin fails++; $display("FAIL add_no_second_done: got %0d pulses expected 0", n); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    int nb = 0;
    go(3'b100, 8'hFF, 8'hFF);
    tick();
    nb += int'(busy);
    checks++; if (done1 !== 1'b0) begin fails++; $display("FAIL mul1_early: got %b expected 0", done1); end
    for (int i = 0; i < 2; i++) begin
      tick();
      nb += int'(busy);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL mul_early_done: cycle %0d got %b expected 0", i + 1, done); end
      if (i == 0) begin
        checks++; if (done1 !== 1'b1 || result1 !== 16'hFE01) begin fails++; $display("FAIL mul1_done: got done=%b result=%h expected 1 fe01", done1, result1); end
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL mul_done: got %b expected 1", done); end
    checks++; if (result !== 16'hFE01) begin fails++; $display("FAIL mul_result: got %h expected fe01", result); end
    checks++; if (nb != 3) begin fails++; $display("FAIL mul_busy_cycles: got %0d expected 3", nb); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    go(3'b010, 8'hF0, 8'h3C);
    tick(); tick();
    checks++; if (done !== 1'b1 || result !== 16'h0030) begin fails++; $display("FAIL and_result: got done=%b result=%h expected 1 0030", done, result); end
    start = 1'b0;
    tick();
    go(3'b011, 8'hF0, 8'h3C);
    tick(); tick();
    checks++; if (done !== 1'b1 || result !== 16'h00CC) begin fails++; $display("FAIL xor_result: got done=%b result=%h expected 1 00cc", done, result); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    go(3'b101, 8'h11, 8'h22);
    tick(); tick();
    checks++; if (done !== 1'b1 || result !== 16'h0000) begin fails++; $display("FAIL illegal_op: got done=%b result=%h expected 1 0000", done, result); end
    start = 1'b0;
    tick();
    go(3'b001, 8'h80, 8'h01);
    tick(); tick();
    checks++; if (result !== 16'h0081) begin fails++; $display("FAIL add_small: got %h expected 0081", result); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_noop_rst();
    int n = 0;
    go(3'b000, 8'h12, 8'h34);
    tick();
    n += int'(done);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); n += int'(done); end
    checks++; if (n != 0 || busy !== 1'b0) begin fails++; $display("FAIL noop_done: got %0d pulses busy=%b expected 0 0", n, busy); end
    checks++; if (result !== 16'h0081) begin fails++; $display("FAIL noop_result: got %h expected 0081", result); end
    go(3'b111, 8'h00, 8'h00);
    tick();
    checks++; if (result !== 16'h0000 || done !== 1'b0) begin fails++; $display("FAIL rst_op: got result=%h done=%b expected 0000 0", result, done); end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_op_after: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_reset_mid_mul();
    int n = 0;
    go(3'b001, 8'h01, 8'h02);
    tick(); tick();
    start = 1'b0;
    tick();
    go(3'b100, 8'hFF, 8'hFF);
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin fails++; $display("FAIL reset_mid_mul: got done=%b busy=%b result=%h expected 0 0 0000", done, busy, result); end
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); n += int'(done); end
    checks++; if (n != 0 || result !== 16'h0000) begin fails++; $display("FAIL reset_mid_mul_after: got %0d pulses result=%h expected 0 0000", n, result); end
    go(3'b001, 8'h05, 8'h06);
    tick(); tick();
    checks++; if (done !== 1'b1 || result !== 16'h000B) begin fails++; $display("FAIL add_after_reset: got done=%b result=%h expected 1 000b", done, result); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_latch();
    go(3'b100, 8'h12, 8'h34);
    tick();
    go(3'b011, 8'h00, 8'h00);
    tick();
    checks++; if (done1 !== 1'b1 || result1 !== 16'h03A8) begin fails++; $display("FAIL latch_mul1: got done=%b result=%h expected 1 03a8", done1, result1); end
    tick(); tick();
    checks++; if (done !== 1'b1 || result !== 16'h03A8) begin fails++; $display("FAIL latch_mul: got done=%b result=%h expected 1 03a8", done, result); end
    start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_noop_rst();
    test_reset_mid_mul();
    test_latch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
